// File: rtl/shift_register_arbiter_pkg.sv
// rtl/shift_register_arbiter_pkg.sv - shared types for the delay-line arbiter
package shift_register_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        GAP   = 2'd2
    } state_e;

    // Wide enough for any practical requester count; tops use the low IDW bits.
    localparam int SRC_W = 8;

    typedef struct packed {
        logic             valid;
        logic [SRC_W-1:0] src;
        logic             last;
        logic             trunc;
    } tag_t;

    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shift_register_arbiter_if.sv
// rtl/shift_register_arbiter_if.sv - requester, delay-line and output bundle
interface shift_register_arbiter_if
    import shift_register_arbiter_pkg::*;
#(
    parameter int N_REQ = 4
) ();
    localparam int IDW = idw(N_REQ);

    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic [7:0]         sr_din;
    logic               sr_ren_n;
    logic [7:0]         sr_dout;
    logic               out_valid;
    logic [7:0]         out_data;
    logic [IDW-1:0]     out_src;
    logic               out_last;
    logic               out_trunc;
    logic               busy;

    modport master (
        output req_valid, req_data, req_last, sr_dout,
        input  req_ready, sr_din, sr_ren_n,
        input  out_valid, out_data, out_src, out_last, out_trunc, busy
    );

    modport slave (
        input  req_valid, req_data, req_last, sr_dout,
        output req_ready, sr_din, sr_ren_n,
        output out_valid, out_data, out_src, out_last, out_trunc, busy
    );

endinterface

// File: rtl/shift_register_arbiter_rr.sv
// rtl/shift_register_arbiter_rr.sv - combinational round-robin pick starting at a pointer
module rr_arbiter
    import shift_register_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IDW  = idw(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDW-1:0]   i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDW-1:0]   o_idx,
    output logic             o_any
);

    logic           w_found;
    int             w_j;
    logic [IDW-1:0] w_jx;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = 0;
        w_jx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_j  = (int'(i_ptr) + k) % N_REQ;
            w_jx = IDW'(w_j);
            if (!w_found && i_req[w_jx]) begin
                w_found       = 1'b1;
                o_grant[w_jx] = 1'b1;
                o_idx         = w_jx;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/shift_register_arbiter.sv
// rtl/shift_register_arbiter.sv - burst round-robin sharing of one byte delay line
// Tags ride a parallel LEN-deep pipeline so dout regains valid/src/last at the far end.
module shift_register_arbiter
    import shift_register_arbiter_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int LEN        = 4,
    parameter int GAP_CYCLES = 1,
    parameter int MAX_BURST  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    shift_register_arbiter_if.slave   bus
);

    localparam int IDW = idw(N_REQ);
    localparam int CW  = $clog2(MAX_BURST + 1);
    localparam int GW  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    state_e         r_state;
    state_e         w_next;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_grant;
    logic [CW-1:0]  r_count;
    logic [GW-1:0]  r_gap;
    tag_t           r_tag [LEN];

    logic [N_REQ-1:0] w_grant_oh;
    logic [IDW-1:0]   w_arb_idx;
    logic             w_any;
    logic             w_sel_valid;
    logic             w_sel_last;
    logic [7:0]       w_sel_data;
    logic             w_accept;
    logic             w_hit_max;
    logic             w_close;
    logic             w_trunc;
    logic [IDW-1:0]   w_ptr_next;
    logic [N_REQ-1:0] w_ready;
    tag_t             w_tag_in;
    logic             w_tag_any;
    logic             w_unused_src;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant_oh),
        .o_idx   (w_arb_idx),
        .o_any   (w_any)
    );

    assign w_sel_valid = bus.req_valid[r_grant];
    assign w_sel_last  = bus.req_last[r_grant];
    assign w_sel_data  = bus.req_data[int'(r_grant) * 8 +: 8];
    assign w_accept    = (r_state == BURST) && w_sel_valid;
    assign w_hit_max   = (r_count == CW'(MAX_BURST - 1));
    assign w_close     = w_accept && (w_sel_last || w_hit_max);
    assign w_trunc     = w_accept && w_hit_max && !w_sel_last;
    assign w_ptr_next  = (r_grant == IDW'(N_REQ - 1)) ? '0 : r_grant + 1'b1;

    always_comb begin
        w_next  = r_state;
        w_ready = '0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_next = BURST;
                end
            end
            BURST: begin
                w_ready = N_REQ'(1) << r_grant;
                if (w_close) begin
                    w_next = (GAP_CYCLES > 0) ? GAP : IDLE;
                end
            end
            GAP: begin
                if (r_gap == GW'(GAP_CYCLES - 1)) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_grant <= '0;
            r_count <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_any) begin
                r_grant <= w_arb_idx;
            end
            if (w_accept) begin
                r_count <= w_close ? '0 : r_count + 1'b1;
            end
            if (w_close) begin
                r_ptr <= w_ptr_next;
            end
            r_gap <= (r_state == GAP) ? r_gap + 1'b1 : '0;
        end
    end

    // Stage 0 mirrors what the delay line captures: a bubble loads an all-zero tag.
    always_comb begin
        w_tag_in = '0;
        if (w_accept) begin
            w_tag_in.valid = 1'b1;
            w_tag_in.src   = SRC_W'(r_grant);
            w_tag_in.last  = w_close;
            w_tag_in.trunc = w_trunc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LEN; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0] <= w_tag_in;
            for (int i = 1; i < LEN; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    always_comb begin
        w_tag_any = 1'b0;
        for (int i = 0; i < LEN; i++) begin
            w_tag_any = w_tag_any | r_tag[i].valid;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.sr_ren_n  = ~w_accept;
    assign bus.sr_din    = w_accept ? w_sel_data : 8'h00;
    assign bus.out_valid = r_tag[LEN-1].valid;
    assign bus.out_data  = bus.sr_dout;
    assign bus.out_src   = r_tag[LEN-1].src[IDW-1:0];
    assign bus.out_last  = r_tag[LEN-1].last;
    assign bus.out_trunc = r_tag[LEN-1].trunc;
    assign bus.busy      = (r_state != IDLE) || w_tag_any;

    assign w_unused_src = ^{r_tag[LEN-1].src, w_grant_oh};

endmodule
